int_issue_queue: RTL and testbench
==================================

Name: int_issue_queue

Overview:
- Collapsing, age-ordered issue queue directly downstream of dispatch. It consumes the dispatch instr0 stream and holds instructions until their source pregs are ready.
- Tracks operand readiness via writeback wakeup and issues at most one ready instruction per cycle, oldest first, to the integer execute stage.
- Supports branch-redirect flush by ROB index.

Parameters:
DEPTH, 8, number of queue entries (power of two, >=2)
PAYLOAD_W, `ISQ_PAYLOAD_W, packed width of pass-through decode/rename fields (pc, instr, imm, types, lrd, old_prd, ls_size, flags)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
enq_valid  in  1  dispatch instr0 valid
enq_ready  out  1  queue can accept (drives dispatch to_issue_instr0_ready)
enq_payload  in  PAYLOAD_W  packed pass-through fields
enq_src1_is_reg  in  1  src1 reads a preg
enq_src2_is_reg  in  1  src2 reads a preg
enq_prs1  in  `PREG_RANGE  src1 preg
enq_prs2  in  `PREG_RANGE  src2 preg
enq_src1_busy  in  1  busy-table state of prs1 at enqueue
enq_src2_busy  in  1  busy-table state of prs2 at enqueue
enq_prd  in  `PREG_RANGE  destination preg
enq_need_to_wb  in  1  writes prd
enq_robidx_flag  in  1  ROB wrap flag
enq_robidx  in  `ROB_SIZE_LOG  ROB index
wb0_valid, wb1_valid  in  1 each  writeback wakeup valid
wb0_prd, wb1_prd  in  `PREG_RANGE each  woken preg
flush_valid  in  1  redirect flush
flush_robidx_flag  in  1  flush point flag
flush_robidx  in  `ROB_SIZE_LOG  flush point index (the branch itself survives)
issue_valid  out  1  oldest ready entry presented
issue_ready  in  1  execute accepts
issue_payload, issue_prs1, issue_prs2, issue_prd, issue_src1_is_reg, issue_src2_is_reg, issue_need_to_wb, issue_robidx_flag, issue_robidx  out  as enq  selected entry fields
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async, reset=1): all entry valids 0, count=0, issue_valid=0, enq_ready=1. Data fields need no reset.
- Storage: entry 0 is oldest. Valid entries are contiguous from 0 to count-1.
- enq_ready = (count != DEPTH) & ~flush_valid. It is registered-state based and independent of issue_ready.
- Enqueue fires on enq_valid & enq_ready. The new entry is written at position count minus (1 if an issue fires this cycle), i.e. the tail after collapse.
- Source ready at enqueue:
  - srcN_rdy = ~srcN_is_reg | ~enq_srcN_busy | (wb0_valid & wb0_prd==prsN) | (wb1_valid & wb1_prd==prsN).
  - Preg 0 is always ready.
- Wakeup: each cycle, every valid entry with a matching wbX_prd on a valid wb port sets that source's rdy on the next clock edge.
- Select: issue_valid = ~flush_valid and at least one valid entry has src1_rdy & src2_rdy. The lowest-index such entry drives the issue_* outputs combinationally from registers.
  - Latency: enqueue at cycle t, earliest issue t+1.
  - A wakeup at t makes the entry issuable at t+1.
- Issue fires on issue_valid & issue_ready. The selected entry is removed, entries above it shift down by one, and count decrements.
- Holding: if issue_ready=0, the selection may change on a later cycle when an older entry becomes ready. There is no stickiness requirement.
- Simultaneous enqueue and issue: count is unchanged. The shift and tail write occur in the same edge with no bubble. Full plus simultaneous issue still rejects the enqueue, because enq_ready is computed from the registered count.
- Flush:
  - An entry is killed if younger than the flush point: (flag==flush_flag & idx>flush_idx) | (flag!=flush_flag & idx<flush_idx).
  - Age order guarantees killed entries form a suffix. count becomes the number of survivors on the next edge.
  - In the flush cycle, enqueue and issue are both blocked.
  - Wakeups arriving in the flush cycle still apply to survivors.
- Reset mid-operation clears everything immediately. No partial state is retained.

Decomposition:
- The shared package (isq_pkg) holds:
  - `ISQ_PAYLOAD_W and a packed isq_payload_t struct for the pass-through fields.
  - isq_entry_t (valid, src rdy bits, prs/prd, robidx).
  - A function rob_younger(flag_a, idx_a, flag_b, idx_b), reused by ROB and LSQ.
- One natural sub-module: isq_entry_wakeup. It is per-entry combinational CAM compare of prs1/prs2 against both wb ports and produces next-rdy bits. It is instantiated DEPTH times plus once for the enqueue bypass.

Test Plan:
- Basic: enqueue robidx 0..3 with all sources ready, issue_ready=1 -> issue in order 0,1,2,3 on consecutive cycles starting t+1; count returns to 0.
- Wakeup and bypass:
  - Enqueue entry A (prs1=5 busy), then entry B (all ready) -> B issues first.
  - wb0 prd=5 at cycle t -> A issues at t+1.
  - Enqueue with prs2=7 busy while wb1 prd=7 is in the same cycle -> issuable next cycle.
- Full and simultaneous: fill 8 entries -> enq_ready=0. Issue one -> enq_ready=1 the next cycle. Hold enq_valid plus issue for 20 cycles -> count stays 7..8 with no loss, and issued robidx are strictly increasing.
- Flush with wrap:
  - Entries have (flag,idx) = (0,30),(0,31),(1,0),(1,1); flush at (0,31) -> count=2 and (1,0),(1,1) are never issued.
  - An enqueue attempted in the flush cycle is not accepted.
- Back-pressure: issue_ready=0 for 5 cycles with 3 ready entries -> issue_valid stays 1, nothing is removed, and the oldest is issued first when issue_ready rises.
- Reset: assert reset with 5 entries, 2 pending wakeups, and issue_valid=1 -> issue_valid=0, count=0, enq_ready=1 immediately, and no stale issue after deassertion.

Source files
------------

// File: rtl/isq_pkg.sv
// Shared types, widths and ROB age helper for the integer issue queue.
`ifndef ISQ_PKG_DEFS
`define ISQ_PKG_DEFS
`define ISQ_PAYLOAD_W 117
`define PREG_RANGE 5:0
`define ROB_SIZE_LOG 5
`endif

package isq_pkg;

    localparam int unsigned PREG_W        = 6;
    localparam int unsigned ROB_W         = `ROB_SIZE_LOG;
    localparam int unsigned ISQ_PAYLOAD_W = `ISQ_PAYLOAD_W;

    // Decode/rename fields carried through the queue untouched
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] imm;
        logic [3:0]  types;
        logic [4:0]  lrd;
        logic [5:0]  old_prd;
        logic [1:0]  ls_size;
        logic [3:0]  flags;
    } isq_payload_t;

    // Scheduling state of one queue slot
    typedef struct packed {
        logic              valid;
        logic              src1_rdy;
        logic              src2_rdy;
        logic              src1_is_reg;
        logic              src2_is_reg;
        logic [PREG_W-1:0] prs1;
        logic [PREG_W-1:0] prs2;
        logic [PREG_W-1:0] prd;
        logic              need_to_wb;
        logic              robidx_flag;
        logic [ROB_W-1:0]  robidx;
    } isq_entry_t;

    // True when ROB position a is strictly younger than position b
    function automatic logic rob_younger(
        input logic             flag_a,
        input logic [ROB_W-1:0] idx_a,
        input logic             flag_b,
        input logic [ROB_W-1:0] idx_b
    );
        return ((flag_a == flag_b) && (idx_a > idx_b)) ||
               ((flag_a != flag_b) && (idx_a < idx_b));
    endfunction

endpackage

// File: rtl/isq_entry_wakeup.sv
// Per-entry CAM compare of source pregs against both writeback ports.
module isq_entry_wakeup
    import isq_pkg::*;
(
    input  logic              src1_rdy,
    input  logic              src2_rdy,
    input  logic [PREG_W-1:0] prs1,
    input  logic [PREG_W-1:0] prs2,
    input  logic              wb0_valid,
    input  logic [PREG_W-1:0] wb0_prd,
    input  logic              wb1_valid,
    input  logic [PREG_W-1:0] wb1_prd,
    output logic              src1_rdy_nxt,
    output logic              src2_rdy_nxt
);

    // A source becomes ready once any valid writeback names its preg
    always_comb begin
        src1_rdy_nxt = src1_rdy | (wb0_valid & (wb0_prd == prs1)) | (wb1_valid & (wb1_prd == prs1));
        src2_rdy_nxt = src2_rdy | (wb0_valid & (wb0_prd == prs2)) | (wb1_valid & (wb1_prd == prs2));
    end

endmodule

// File: rtl/int_issue_queue.sv
// Collapsing age-ordered integer issue queue: entry 0 is oldest, one issue per cycle.
module int_issue_queue
    import isq_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned PAYLOAD_W = ISQ_PAYLOAD_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  logic [PAYLOAD_W-1:0]   enq_payload,
    input  logic                   enq_src1_is_reg,
    input  logic                   enq_src2_is_reg,
    input  logic [PREG_W-1:0]      enq_prs1,
    input  logic [PREG_W-1:0]      enq_prs2,
    input  logic                   enq_src1_busy,
    input  logic                   enq_src2_busy,
    input  logic [PREG_W-1:0]      enq_prd,
    input  logic                   enq_need_to_wb,
    input  logic                   enq_robidx_flag,
    input  logic [ROB_W-1:0]       enq_robidx,
    input  logic                   wb0_valid,
    input  logic [PREG_W-1:0]      wb0_prd,
    input  logic                   wb1_valid,
    input  logic [PREG_W-1:0]      wb1_prd,
    input  logic                   flush_valid,
    input  logic                   flush_robidx_flag,
    input  logic [ROB_W-1:0]       flush_robidx,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [PAYLOAD_W-1:0]   issue_payload,
    output logic [PREG_W-1:0]      issue_prs1,
    output logic [PREG_W-1:0]      issue_prs2,
    output logic [PREG_W-1:0]      issue_prd,
    output logic                   issue_src1_is_reg,
    output logic                   issue_src2_is_reg,
    output logic                   issue_need_to_wb,
    output logic                   issue_robidx_flag,
    output logic [ROB_W-1:0]       issue_robidx,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned SEL_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = SEL_W + 1;

    isq_entry_t           ent_q [DEPTH];
    isq_entry_t           ent_d [DEPTH];
    isq_entry_t           woke  [DEPTH];
    logic [PAYLOAD_W-1:0] pay_q [DEPTH];
    logic [PAYLOAD_W-1:0] pay_d [DEPTH];
    logic [CNT_W-1:0]     count_q, count_d, tail, survivors;
    logic [DEPTH-1:0]     rdy1_nxt, rdy2_nxt, ready, killed;
    logic [SEL_W-1:0]     sel;
    logic                 enq_fire, issue_fire;
    logic                 enq_rdy1_base, enq_rdy2_base, enq_rdy1, enq_rdy2;
    isq_entry_t           enq_ent;

    for (genvar g = 0; g < DEPTH; g++) begin : g_wake
        isq_entry_wakeup u_wake (
            .src1_rdy     (ent_q[g].src1_rdy),
            .src2_rdy     (ent_q[g].src2_rdy),
            .prs1         (ent_q[g].prs1),
            .prs2         (ent_q[g].prs2),
            .wb0_valid    (wb0_valid),
            .wb0_prd      (wb0_prd),
            .wb1_valid    (wb1_valid),
            .wb1_prd      (wb1_prd),
            .src1_rdy_nxt (rdy1_nxt[g]),
            .src2_rdy_nxt (rdy2_nxt[g])
        );
    end

    // Preg 0 and non-register sources are ready on arrival
    assign enq_rdy1_base = ~enq_src1_is_reg | ~enq_src1_busy | (enq_prs1 == '0);
    assign enq_rdy2_base = ~enq_src2_is_reg | ~enq_src2_busy | (enq_prs2 == '0);

    isq_entry_wakeup u_enq_bypass (
        .src1_rdy     (enq_rdy1_base),
        .src2_rdy     (enq_rdy2_base),
        .prs1         (enq_prs1),
        .prs2         (enq_prs2),
        .wb0_valid    (wb0_valid),
        .wb0_prd      (wb0_prd),
        .wb1_valid    (wb1_valid),
        .wb1_prd      (wb1_prd),
        .src1_rdy_nxt (enq_rdy1),
        .src2_rdy_nxt (enq_rdy2)
    );

    // Per-entry readiness, flush kill mask, survivor count and wakeup-applied view
    always_comb begin
        survivors = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i]  = ent_q[i].valid & ent_q[i].src1_rdy & ent_q[i].src2_rdy;
            killed[i] = ent_q[i].valid & rob_younger(ent_q[i].robidx_flag, ent_q[i].robidx,
                                                     flush_robidx_flag, flush_robidx);
            survivors = survivors + CNT_W'(ent_q[i].valid & ~killed[i]);
            woke[i]          = ent_q[i];
            woke[i].src1_rdy = rdy1_nxt[i];
            woke[i].src2_rdy = rdy2_nxt[i];
        end
    end

    // Oldest ready entry wins selection
    always_comb begin
        sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) sel = SEL_W'(i);
        end
    end

    assign enq_ready   = (count_q != CNT_W'(DEPTH)) & ~flush_valid;
    assign issue_valid = (|ready) & ~flush_valid;
    assign enq_fire    = enq_valid & enq_ready;
    assign issue_fire  = issue_valid & issue_ready;
    assign tail        = count_q - CNT_W'(issue_fire);
    assign count       = count_q;

    assign issue_payload     = pay_q[sel];
    assign issue_prs1        = ent_q[sel].prs1;
    assign issue_prs2        = ent_q[sel].prs2;
    assign issue_prd         = ent_q[sel].prd;
    assign issue_src1_is_reg = ent_q[sel].src1_is_reg;
    assign issue_src2_is_reg = ent_q[sel].src2_is_reg;
    assign issue_need_to_wb  = ent_q[sel].need_to_wb;
    assign issue_robidx_flag = ent_q[sel].robidx_flag;
    assign issue_robidx      = ent_q[sel].robidx;

    // Newly dispatched entry with bypassed readiness
    always_comb begin
        enq_ent             = '0;
        enq_ent.valid       = 1'b1;
        enq_ent.src1_rdy    = enq_rdy1;
        enq_ent.src2_rdy    = enq_rdy2;
        enq_ent.src1_is_reg = enq_src1_is_reg;
        enq_ent.src2_is_reg = enq_src2_is_reg;
        enq_ent.prs1        = enq_prs1;
        enq_ent.prs2        = enq_prs2;
        enq_ent.prd         = enq_prd;
        enq_ent.need_to_wb  = enq_need_to_wb;
        enq_ent.robidx_flag = enq_robidx_flag;
        enq_ent.robidx      = enq_robidx;
    end

    // Next storage: flush truncates the young suffix, else collapse on issue then tail write
    always_comb begin
        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = woke[i];
            pay_d[i] = pay_q[i];
        end
        if (flush_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (killed[i]) ent_d[i].valid = 1'b0;
            end
            count_d = survivors;
        end else begin
            if (issue_fire) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    if (SEL_W'(i) >= sel) begin
                        ent_d[i] = woke[i + 1];
                        pay_d[i] = pay_q[i + 1];
                    end
                end
                ent_d[DEPTH - 1].valid = 1'b0;
            end
            if (enq_fire) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CNT_W'(i) == tail) begin
                        ent_d[i] = enq_ent;
                        pay_d[i] = enq_payload;
                    end
                end
            end
            count_d = count_q + CNT_W'(enq_fire) - CNT_W'(issue_fire);
        end
    end

    // Scheduling state and occupancy, cleared asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
        end
    end

    // Pass-through payload storage
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) pay_q[i] <= pay_d[i];
    end

endmodule

// File: tb/tb_int_issue_queue.sv
// Bench for int_issue_queue: directed phases plus random traffic against a queue-based model.
module tb_int_issue_queue;
    import isq_pkg::*;

    localparam int DEPTH = 8;
    localparam int PW    = ISQ_PAYLOAD_W;

    logic              clock, reset;
    logic              enq_valid, enq_ready;
    logic [PW-1:0]     enq_payload;
    logic              enq_src1_is_reg, enq_src2_is_reg, enq_src1_busy, enq_src2_busy;
    logic [5:0]        enq_prs1, enq_prs2, enq_prd;
    logic              enq_need_to_wb, enq_robidx_flag;
    logic [4:0]        enq_robidx;
    logic              wb0_valid, wb1_valid;
    logic [5:0]        wb0_prd, wb1_prd;
    logic              flush_valid, flush_robidx_flag;
    logic [4:0]        flush_robidx;
    logic              issue_valid, issue_ready;
    logic [PW-1:0]     issue_payload;
    logic [5:0]        issue_prs1, issue_prs2, issue_prd;
    logic              issue_src1_is_reg, issue_src2_is_reg, issue_need_to_wb, issue_robidx_flag;
    logic [4:0]        issue_robidx;
    logic [3:0]        count;

    int_issue_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
        .clock(clock), .reset(reset),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_payload(enq_payload),
        .enq_src1_is_reg(enq_src1_is_reg), .enq_src2_is_reg(enq_src2_is_reg),
        .enq_prs1(enq_prs1), .enq_prs2(enq_prs2),
        .enq_src1_busy(enq_src1_busy), .enq_src2_busy(enq_src2_busy),
        .enq_prd(enq_prd), .enq_need_to_wb(enq_need_to_wb),
        .enq_robidx_flag(enq_robidx_flag), .enq_robidx(enq_robidx),
        .wb0_valid(wb0_valid), .wb0_prd(wb0_prd), .wb1_valid(wb1_valid), .wb1_prd(wb1_prd),
        .flush_valid(flush_valid), .flush_robidx_flag(flush_robidx_flag), .flush_robidx(flush_robidx),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_payload(issue_payload),
        .issue_prs1(issue_prs1), .issue_prs2(issue_prs2), .issue_prd(issue_prd),
        .issue_src1_is_reg(issue_src1_is_reg), .issue_src2_is_reg(issue_src2_is_reg),
        .issue_need_to_wb(issue_need_to_wb), .issue_robidx_flag(issue_robidx_flag),
        .issue_robidx(issue_robidx), .count(count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [5:0]    rob;
        logic [5:0]    prs1, prs2, prd;
        logic          r1, r2, isr1, isr2, nwb;
        logic [PW-1:0] pay;
    } m_ent_t;

    m_ent_t     mq[$];
    logic [5:0] rob_ctr;
    int         n_pass, n_total;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit woken(input logic [5:0] p);
        return (wb0_valid && wb0_prd == p) || (wb1_valid && wb1_prd == p);
    endfunction

    // a younger than b when it lies 1..31 steps ahead on the 64-position flag+index ring
    function automatic bit younger(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] d;
        d = a - b;
        return (d >= 6'd1) && (d <= 6'd31);
    endfunction

    task automatic idle();
        enq_valid = 0; wb0_valid = 0; wb1_valid = 0; flush_valid = 0;
    endtask

    task automatic drive_enq(input bit v, input bit isr1, input bit b1, input logic [5:0] p1,
                             input bit isr2, input bit b2, input logic [5:0] p2);
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        enq_valid = v;
        enq_src1_is_reg = isr1; enq_src1_busy = b1; enq_prs1 = p1;
        enq_src2_is_reg = isr2; enq_src2_busy = b2; enq_prs2 = p2;
        enq_prd = 6'($urandom_range(1, 63));
        enq_need_to_wb = 1'($urandom());
        enq_payload = r[PW-1:0];
        enq_robidx_flag = rob_ctr[5];
        enq_robidx = rob_ctr[4:0];
    endtask

    // One clock: compare DUT against the model mid-cycle, then advance the model
    task automatic cyc();
        int     sel;
        bit     found, exp_iv, exp_er, fire_i, fire_e;
        m_ent_t n;
        m_ent_t keep[$];
        logic [5:0] fp;
        #3;
        found = 0; sel = 0;
        foreach (mq[k]) if (!found && mq[k].r1 && mq[k].r2) begin found = 1; sel = k; end
        exp_er = (mq.size() != DEPTH) && !flush_valid;
        exp_iv = found && !flush_valid;
        chk("count", 128'(count), 128'(mq.size()));
        chk("enq_ready", 128'(enq_ready), 128'(exp_er));
        chk("issue_valid", 128'(issue_valid), 128'(exp_iv));
        if (exp_iv) begin
            chk("issue_rob", 128'({issue_robidx_flag, issue_robidx}), 128'(mq[sel].rob));
            chk("issue_prs", 128'({issue_prs1, issue_prs2, issue_prd}),
                128'({mq[sel].prs1, mq[sel].prs2, mq[sel].prd}));
            chk("issue_flags", 128'({issue_src1_is_reg, issue_src2_is_reg, issue_need_to_wb}),
                128'({mq[sel].isr1, mq[sel].isr2, mq[sel].nwb}));
            chk("issue_payload", 128'(issue_payload), 128'(mq[sel].pay));
        end
        fire_i = exp_iv && issue_ready;
        fire_e = enq_valid && exp_er;
        n.rob = rob_ctr; n.prs1 = enq_prs1; n.prs2 = enq_prs2; n.prd = enq_prd;
        n.isr1 = enq_src1_is_reg; n.isr2 = enq_src2_is_reg; n.nwb = enq_need_to_wb;
        n.pay = enq_payload;
        n.r1 = !enq_src1_is_reg || !enq_src1_busy || enq_prs1 == 0 || woken(enq_prs1);
        n.r2 = !enq_src2_is_reg || !enq_src2_busy || enq_prs2 == 0 || woken(enq_prs2);
        foreach (mq[k]) begin
            if (woken(mq[k].prs1)) mq[k].r1 = 1;
            if (woken(mq[k].prs2)) mq[k].r2 = 1;
        end
        if (flush_valid) begin
            fp = {flush_robidx_flag, flush_robidx};
            foreach (mq[k]) if (!younger(mq[k].rob, fp)) keep.push_back(mq[k]);
            mq = keep;
            rob_ctr = fp + 6'd1;
        end else begin
            if (fire_i) mq.delete(sel);
            if (fire_e) begin mq.push_back(n); rob_ctr = rob_ctr + 6'd1; end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        int k;
        logic [5:0] fp;
        n_pass = 0; n_total = 0; rob_ctr = 0;
        reset = 1; issue_ready = 0;
        idle();
        drive_enq(0, 0, 0, 0, 0, 0, 0);
        wb0_prd = 0; wb1_prd = 0; flush_robidx_flag = 0; flush_robidx = 0;
        @(posedge clock); #1;
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_enq_ready", 128'(enq_ready), 128'(1));
        chk("rst_issue_valid", 128'(issue_valid), 128'(0));
        @(posedge clock); #1;
        reset = 0;

        // Basic in-order issue of four ready entries
        issue_ready = 1;
        for (int i = 0; i < 4; i++) begin drive_enq(1, 1, 0, 6'(i + 1), 0, 0, 0); cyc(); end
        idle();
        for (int i = 0; i < 3; i++) cyc();

        // Younger ready entry overtakes an older blocked one, then wakeup releases it
        drive_enq(1, 1, 1, 6'd5, 0, 0, 0); cyc();
        drive_enq(1, 0, 0, 6'd0, 0, 0, 0); cyc();
        idle(); cyc();
        wb0_valid = 1; wb0_prd = 6'd5; cyc();
        idle(); cyc(); cyc();

        // Enqueue-cycle bypass of a busy source
        drive_enq(1, 0, 0, 0, 1, 1, 6'd7); wb1_valid = 1; wb1_prd = 6'd7; cyc();
        idle(); cyc(); cyc();

        // Fill to full, then sustained enqueue alongside issue
        issue_ready = 0;
        for (int i = 0; i < 9; i++) begin drive_enq(1, 0, 0, 0, 0, 0, 0); cyc(); end
        idle(); issue_ready = 1; cyc();
        for (int i = 0; i < 20; i++) begin drive_enq(1, 1, 0, 6'd3, 1, 0, 6'd4); cyc(); end
        idle();
        for (int i = 0; i < 10; i++) cyc();

        // Flush across the ROB wrap with an enqueue attempt in the flush cycle
        rob_ctr = 6'd30;
        for (int i = 0; i < 4; i++) begin drive_enq(1, 1, 1, 6'd9, 0, 0, 0); cyc(); end
        drive_enq(1, 0, 0, 0, 0, 0, 0);
        flush_valid = 1; flush_robidx_flag = 0; flush_robidx = 5'd31; cyc();
        idle(); cyc();
        wb0_valid = 1; wb0_prd = 6'd9; cyc();
        idle();
        for (int i = 0; i < 4; i++) cyc();

        // Back-pressure with three ready entries
        issue_ready = 0;
        for (int i = 0; i < 3; i++) begin drive_enq(1, 0, 0, 0, 0, 0, 0); cyc(); end
        idle();
        for (int i = 0; i < 5; i++) cyc();
        issue_ready = 1;
        for (int i = 0; i < 4; i++) cyc();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            drive_enq($urandom_range(0, 3) != 0,
                      1'($urandom()), 1'($urandom()), 6'($urandom_range(0, 15)),
                      1'($urandom()), 1'($urandom()), 6'($urandom_range(0, 15)));
            wb0_valid = 1'($urandom()); wb0_prd = 6'($urandom_range(0, 15));
            wb1_valid = 1'($urandom()); wb1_prd = 6'($urandom_range(0, 15));
            issue_ready = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 19) == 0) begin
                flush_valid = 1;
                if (mq.size() > 0) begin
                    k = $urandom_range(0, mq.size() - 1);
                    fp = mq[k].rob;
                end else fp = rob_ctr - 6'd1;
                flush_robidx_flag = fp[5]; flush_robidx = fp[4:0];
            end else flush_valid = 0;
            cyc();
        end

        // Reset mid-operation with pending wakeups and a presented issue
        idle(); issue_ready = 1;
        for (int i = 0; i < 12; i++) cyc();
        issue_ready = 0;
        for (int i = 0; i < 3; i++) begin drive_enq(1, 0, 0, 0, 0, 0, 0); cyc(); end
        drive_enq(1, 1, 1, 6'd11, 0, 0, 0); cyc();
        drive_enq(1, 0, 0, 0, 1, 1, 6'd12); cyc();
        idle(); cyc();
        wb0_valid = 1; wb0_prd = 6'd11; wb1_valid = 1; wb1_prd = 6'd12; issue_ready = 1;
        #1 reset = 1;
        #1;
        chk("midrst_issue_valid", 128'(issue_valid), 128'(0));
        chk("midrst_count", 128'(count), 128'(0));
        chk("midrst_enq_ready", 128'(enq_ready), 128'(1));
        mq.delete(); rob_ctr = 0;
        @(posedge clock); #1;
        reset = 0; idle();
        for (int i = 0; i < 3; i++) cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
